// File: rtl/seq_scan_ctrl_if.sv
// Handshake and result bundle between a frame requester and seq_scan_ctrl.
// The master drives the frame request; the slave returns status and results.
interface seq_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [3:0]       pattern;
  logic             busy;
  logic             done;
  logic             found;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       first_pos;

  modport master (
    output start, data, pattern,
    input  busy, done, found, match_count, first_pos
  );

  modport slave (
    input  start, data, pattern,
    output busy, done, found, match_count, first_pos
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serial 4-bit pattern scanner: shifts a latched frame MSB first through a window, counting overlapping matches.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while SCAN or DONE.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  seq_scan_ctrl_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [3:0]       r_pattern;
  logic [3:0]       r_win;
  logic [3:0]       w_win_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_match_count;
  logic             r_found;
  logic [2:0]       r_first_pos;
  logic             w_last;
  logic             w_match;

  // r_data shifts left each scan cycle, so its MSB is always the next bit to consume.
  assign w_win_nxt = {r_win[2:0], r_data[WIDTH-1]};
  assign w_last    = (32'(r_idx) == WIDTH - 1);
  assign w_match   = (32'(r_idx) >= 3) && (w_win_nxt == r_pattern);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SCAN;
      SCAN:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data        <= '0;
      r_pattern     <= '0;
      r_win         <= '0;
      r_idx         <= '0;
      r_match_count <= '0;
      r_found       <= 1'b0;
      r_first_pos   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_data        <= bus.data;
            r_pattern     <= bus.pattern;
            r_win         <= '0;
            r_idx         <= '0;
            r_match_count <= '0;
            r_found       <= 1'b0;
            r_first_pos   <= '0;
          end
        end
        SCAN: begin
          r_data <= r_data << 1;
          r_win  <= w_win_nxt;
          r_idx  <= r_idx + IDX_W'(1);
          if (w_match) begin
            if (r_match_count != {CNT_W{1'b1}}) begin
              r_match_count <= r_match_count + CNT_W'(1);
            end
            if (!r_found) begin
              r_found     <= 1'b1;
              r_first_pos <= 3'(r_idx);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.busy        = (r_state == SCAN);
    bus.done        = (r_state == DONE);
    bus.found       = r_found;
    bus.match_count = r_match_count;
    bus.first_pos   = r_first_pos;
  end
endmodule
